store_coalescer: RTL and testbench

- Sits directly downstream of the store buffer commit queue and upstream of the D$ store port.
- Holds one committed store and merges later committed stores to the same XLEN-aligned word into it.
- Issues the merged write to the D$ when a non-matching store arrives, a drain is requested, or an idle timeout expires.
- Reduces D$ store-port occupancy for byte/halfword store sequences.

---
 rtl/store_coalescer.sv | 205 ++++++++++++++++++++
 tb/tb_store_coalescer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_coalescer.sv
// -----------------------------------------------------------------------------
// store_coalescer
//
// Purpose:
//   Sits between the store buffer commit queue and the D$ store port. Holds one
//   committed store and merges later committed stores to the same XLEN-aligned
//   word into it. The merged write goes to the D$ when a store to a different
//   word arrives, a drain is requested, or the held entry sits idle for TIMEOUT
//   cycles. This cuts D$ store-port occupancy for byte/halfword sequences.
//
// Configuration macro:
//   STORE_COALESCE_EN  defined   : merging, idle timer and HOLD state enabled.
//                      undefined : one-entry registered pass-through, no merging.
//
// Ports:
//   clk_i                  clock
//   rst_ni                 synchronous active-low reset
//   drain_i                force issue of the held entry
//   empty_o                no entry held, no D$ request outstanding
//   page_offset_i          load page offset to compare against the held entry
//   page_offset_matches_o  held entry's address [11:OFF] equals page_offset_i
//   stb_req_i/stb_gnt_o    committed-store handshake from the store buffer
//   stb_paddr_i            store physical address
//   stb_data_i             lane-aligned store data
//   stb_be_i               store byte enables
//   stb_size_i             store size
//   dc_req_o/dc_gnt_i      D$ write handshake
//   dc_paddr_o             word-aligned write address
//   dc_data_o              merged write data
//   dc_be_o                merged byte enables
//   dc_size_o              original size if unmerged, OFF if merged
// -----------------------------------------------------------------------------
module store_coalescer #(
   parameter int unsigned TIMEOUT = 8,
   parameter int unsigned PLEN    = 34,
   parameter int unsigned XLEN    = 32
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                drain_i,
   output logic                empty_o,
   input  logic [11:0]         page_offset_i,
   output logic                page_offset_matches_o,
   input  logic                stb_req_i,
   output logic                stb_gnt_o,
   input  logic [PLEN-1:0]     stb_paddr_i,
   input  logic [XLEN-1:0]     stb_data_i,
   input  logic [XLEN/8-1:0]   stb_be_i,
   input  logic [1:0]          stb_size_i,
   output logic                dc_req_o,
   input  logic                dc_gnt_i,
   output logic [PLEN-1:0]     dc_paddr_o,
   output logic [XLEN-1:0]     dc_data_o,
   output logic [XLEN/8-1:0]   dc_be_o,
   output logic [1:0]          dc_size_o
);

   localparam int unsigned NB  = XLEN / 8;
   localparam int unsigned OFF = $clog2(NB);

   // Masks select the word-index bits; masking keeps every input bit in use.
   localparam logic [PLEN-1:0] ADDR_ALIGN = {PLEN{1'b1}} << OFF;
   localparam logic [11:0]     PAGE_MASK  = 12'hFFF << OFF;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_HOLD  = 2'd1,
      S_ISSUE = 2'd2
   } state_e;

   state_e            state_q;
   logic [PLEN-1:0]   addr_q;
   logic [XLEN-1:0]   data_q;
   logic [NB-1:0]     be_q;
   logic [1:0]        size_q;

   // Byte-lane merge: lanes enabled in be take the new byte, others keep old.
   function automatic logic [XLEN-1:0] merge_lanes(
      input logic [XLEN-1:0] old_data,
      input logic [XLEN-1:0] new_data,
      input logic [NB-1:0]   be
   );
      logic [XLEN-1:0] res;
      res = old_data;
      for (int i = 0; i < NB; i++) begin
         if (be[i]) res[8*i +: 8] = new_data[8*i +: 8];
      end
      return res;
   endfunction

`ifdef STORE_COALESCE_EN
   localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

   logic       merged_q;
   logic [7:0] timer_q;
   logic       match;

   assign match = ((stb_paddr_i ^ addr_q) & ADDR_ALIGN) == '0;
`else
   logic unused_drain;
   assign unused_drain = drain_i;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= S_EMPTY;
         addr_q   <= '0;
         data_q   <= '0;
         be_q     <= '0;
         size_q   <= '0;
`ifdef STORE_COALESCE_EN
         merged_q <= 1'b0;
         timer_q  <= '0;
`endif
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (stb_req_i) begin
                  addr_q   <= stb_paddr_i & ADDR_ALIGN;
                  data_q   <= stb_data_i;
                  be_q     <= stb_be_i;
                  size_q   <= stb_size_i;
`ifdef STORE_COALESCE_EN
                  merged_q <= 1'b0;
                  timer_q  <= '0;
                  state_q  <= S_HOLD;
`else
                  state_q  <= S_ISSUE;
`endif
               end
            end
`ifdef STORE_COALESCE_EN
            S_HOLD: begin
               // Drain outranks a same-cycle merge so a fence sees a stable entry.
               if (drain_i) begin
                  state_q <= S_ISSUE;
               end else if (stb_req_i && match) begin
                  data_q   <= merge_lanes(data_q, stb_data_i, stb_be_i);
                  be_q     <= be_q | stb_be_i;
                  merged_q <= 1'b1;
                  timer_q  <= '0;
               end else if (stb_req_i) begin
                  state_q <= S_ISSUE;
               end else if (timer_q == TIMER_LAST) begin
                  state_q <= S_ISSUE;
               end else begin
                  timer_q <= timer_q + 8'd1;
               end
            end
`endif
            S_ISSUE: begin
               // Entry is frozen until granted; a store arriving in the grant
               // cycle starts a fresh entry and never merges with the old one.
               if (dc_gnt_i) begin
                  if (stb_req_i) begin
                     addr_q   <= stb_paddr_i & ADDR_ALIGN;
                     data_q   <= stb_data_i;
                     be_q     <= stb_be_i;
                     size_q   <= stb_size_i;
`ifdef STORE_COALESCE_EN
                     merged_q <= 1'b0;
                     timer_q  <= '0;
                     state_q  <= S_HOLD;
`else
                     state_q  <= S_ISSUE;
`endif
                  end else begin
                     state_q <= S_EMPTY;
                  end
               end
            end
            default: state_q <= S_EMPTY;
         endcase
      end
   end

   always_comb begin
      stb_gnt_o = 1'b0;
      case (state_q)
         S_EMPTY: stb_gnt_o = 1'b1;
`ifdef STORE_COALESCE_EN
         S_HOLD:  stb_gnt_o = stb_req_i && match && !drain_i;
`endif
         S_ISSUE: stb_gnt_o = dc_gnt_i;
         default: stb_gnt_o = 1'b0;
      endcase
      if (!rst_ni) stb_gnt_o = 1'b0;
   end

   assign dc_req_o   = rst_ni && (state_q == S_ISSUE);
   assign empty_o    = !rst_ni || (state_q == S_EMPTY);
   assign dc_paddr_o = addr_q;
   assign dc_data_o  = data_q;
   assign dc_be_o    = be_q;

`ifdef STORE_COALESCE_EN
   assign dc_size_o  = merged_q ? 2'(OFF) : size_q;
`else
   assign dc_size_o  = size_q;
`endif

   assign page_offset_matches_o = rst_ni && (state_q != S_EMPTY) &&
                                  (((addr_q[11:0] ^ page_offset_i) & PAGE_MASK) == '0);

endmodule

// File: tb/tb_store_coalescer.sv
module tb_store_coalescer;

  localparam int PLEN    = 34;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 8;
`ifdef STORE_COALESCE_EN
  localparam int LAT = TIMEOUT + 1;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [PLEN-1:0] a;
    logic [31:0]     d;
    logic [3:0]      be;
    logic [1:0]      sz;
  } wr_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            drain = 1'b0;
  logic            empty;
  logic [11:0]     page_off = '0;
  logic            pmatch;
  logic            stb_req = 1'b0;
  logic            stb_gnt;
  logic [PLEN-1:0] stb_paddr = '0;
  logic [31:0]     stb_data = '0;
  logic [3:0]      stb_be = '0;
  logic [1:0]      stb_size = '0;
  logic            dc_req;
  logic            dc_gnt;
  logic [PLEN-1:0] dc_paddr;
  logic [31:0]     dc_data;
  logic [3:0]      dc_be;
  logic [1:0]      dc_size;
  logic            gnt_en = 1'b1;

  int  checks = 0;
  int  errors = 0;
  int  cyc_n  = 0;
  wr_t sb[$];
  wr_t exp_wr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  assign dc_gnt = dc_req & gnt_en;

  store_coalescer #(.TIMEOUT(TIMEOUT), .PLEN(PLEN), .XLEN(XLEN)) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .drain_i               (drain),
    .empty_o               (empty),
    .page_offset_i         (page_off),
    .page_offset_matches_o (pmatch),
    .stb_req_i             (stb_req),
    .stb_gnt_o             (stb_gnt),
    .stb_paddr_i           (stb_paddr),
    .stb_data_i            (stb_data),
    .stb_be_i              (stb_be),
    .stb_size_i            (stb_size),
    .dc_req_o              (dc_req),
    .dc_gnt_i              (dc_gnt),
    .dc_paddr_o            (dc_paddr),
    .dc_data_o             (dc_data),
    .dc_be_o               (dc_be),
    .dc_size_o             (dc_size)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [PLEN-1:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic [1:0] sz);
    wr_t w;
    w.a = a; w.d = d; w.be = be; w.sz = sz;
    sb.push_back(w);
  endtask

  // Scoreboard: every granted D$ write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && dc_req && dc_gnt) begin
      if (sb.size() == 0) begin
        chk("sb_has_expected_write", 64'(sb.size() != 0), 64'd1);
      end else begin
        exp_wr = sb.pop_front();
        chk("dc_paddr", 64'(dc_paddr), 64'(exp_wr.a));
        chk("dc_data",  64'(dc_data),  64'(exp_wr.d));
        chk("dc_be",    64'(dc_be),    64'(exp_wr.be));
        chk("dc_size",  64'(dc_size),  64'(exp_wr.sz));
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [PLEN-1:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic [1:0] sz, output int g);
    stb_req = 1'b1; stb_paddr = a; stb_data = d; stb_be = be; stb_size = sz;
    g = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stb_gnt) begin
        g = cyc_n;
        break;
      end
      cyc();
    end
    if (g < 0) chk("stb_gnt_timeout", 64'(stb_gnt), 64'd1);
    cyc();
    stb_req = 1'b0;
  endtask

  task automatic wait_req(output int c);
    c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dc_req) begin
        c = cyc_n;
        break;
      end
      cyc();
    end
    if (c < 0) chk("dc_req_timeout", 64'(dc_req), 64'd1);
    cyc();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (empty && sb.size() == 0) break;
      cyc();
    end
    chk("idle_empty", 64'(empty), 64'd1);
    chk("idle_sb_drained", 64'(sb.size()), 64'd0);
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g, c;

    // Reset state
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_stb_gnt", 64'(stb_gnt), 64'd0);
    chk("rst_dc_req",  64'(dc_req),  64'd0);
    chk("rst_empty",   64'(empty),   64'd1);
    chk("rst_pmatch",  64'(pmatch),  64'd0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_gnt",   64'(stb_gnt), 64'd1);
    chk("post_rst_empty", 64'(empty),   64'd1);
    cyc();

    // Single unmerged store: latency and aligned address
    push(34'h1000_0004, 32'h0000_AB00, 4'b0010, 2'd0);
    send(34'h1000_0005, 32'h0000_AB00, 4'b0010, 2'd0, g);
    wait_req(c);
    chk("lat_single", 64'(c - g), 64'(LAT));
    wait_idle();

    // Four byte stores on consecutive cycles
`ifdef STORE_COALESCE_EN
    push(34'h1000_0000, 32'h4433_2211, 4'hF, 2'd2);
`else
    push(34'h1000_0000, 32'h0000_0011, 4'h1, 2'd0);
    push(34'h1000_0000, 32'h0000_2200, 4'h2, 2'd0);
    push(34'h1000_0000, 32'h0033_0000, 4'h4, 2'd0);
    push(34'h1000_0000, 32'h4400_0000, 4'h8, 2'd0);
`endif
    send(34'h1000_0000, 32'h0000_0011, 4'h1, 2'd0, g);
    send(34'h1000_0001, 32'h0000_2200, 4'h2, 2'd0, g);
    send(34'h1000_0002, 32'h0033_0000, 4'h4, 2'd0, g);
    send(34'h1000_0003, 32'h4400_0000, 4'h8, 2'd0, g);
    wait_idle();

    // Different-word store is held off until the first write is granted
    gnt_en = 1'b0;
    push(34'h2000, 32'hDEAD_BEEF, 4'hF, 2'd2);
    send(34'h2000, 32'hDEAD_BEEF, 4'hF, 2'd2, g);
    push(34'h2004, 32'h1234_5678, 4'hF, 2'd2);
    stb_req = 1'b1; stb_paddr = 34'h2004; stb_data = 32'h1234_5678; stb_be = 4'hF; stb_size = 2'd2;
    @(negedge clk);
    chk("mismatch_gnt_0", 64'(stb_gnt), 64'd0);
    cyc();
    @(negedge clk);
    chk("mismatch_gnt_1", 64'(stb_gnt), 64'd0);
    chk("mismatch_dc_req", 64'(dc_req), 64'd1);
    chk("mismatch_dc_paddr", 64'(dc_paddr), 64'h2000);
    cyc();
    gnt_en = 1'b1;
    @(negedge clk);
    chk("gnt_in_dc_gnt_cycle", 64'(stb_gnt), 64'd1);
    cyc();
    stb_req = 1'b0;
    @(negedge clk);
    chk("second_store_held", 64'(empty), 64'd0);
`ifdef STORE_COALESCE_EN
    chk("second_store_in_hold", 64'(dc_req), 64'd0);
`else
    chk("second_store_in_issue", 64'(dc_req), 64'd1);
`endif
    cyc();
    wait_idle();

    // Drain with a same-word store in the same cycle, delayed D$ grant
    gnt_en = 1'b0;
    push(34'h3000, 32'h0000_005A, 4'h1, 2'd0);
    send(34'h3000, 32'h0000_005A, 4'h1, 2'd0, g);
    drain = 1'b1;
    stb_req = 1'b1; stb_paddr = 34'h3001; stb_data = 32'h0000_6600; stb_be = 4'h2; stb_size = 2'd0;
    @(negedge clk);
    chk("drain_blocks_merge_gnt", 64'(stb_gnt), 64'd0);
    cyc();
    drain = 1'b0;
    stb_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_dc_req",   64'(dc_req),   64'd1);
      chk("stall_dc_paddr", 64'(dc_paddr), 64'h3000);
      chk("stall_dc_data",  64'(dc_data),  64'h5A);
      chk("stall_dc_be",    64'(dc_be),    64'h1);
      chk("stall_dc_size",  64'(dc_size),  64'd0);
      cyc();
    end
    gnt_en = 1'b1;
    cyc();
    @(negedge clk);
    chk("empty_after_grant", 64'(empty), 64'd1);
    cyc();

    // Page offset compare
    gnt_en = 1'b0;
    push(34'h8000_0104, 32'h00CC_0000, 4'h4, 2'd0);
    send(34'h8000_0106, 32'h00CC_0000, 4'h4, 2'd0, g);
    page_off = 12'h104;
    @(negedge clk);
    chk("pmatch_same_word", 64'(pmatch), 64'd1);
    cyc();
    page_off = 12'h108;
    @(negedge clk);
    chk("pmatch_other_word", 64'(pmatch), 64'd0);
    cyc();
    gnt_en = 1'b1;
    wait_idle();
    page_off = 12'h104;
    @(negedge clk);
    chk("pmatch_empty", 64'(pmatch), 64'd0);
    cyc();

    // Same-lane overwrite after idle gap; timer restarts on merge
`ifdef STORE_COALESCE_EN
    push(34'h5000, 32'h0000_0077, 4'h1, 2'd2);
`else
    push(34'h5000, 32'h0000_0001, 4'h1, 2'd0);
    push(34'h5000, 32'h0000_0077, 4'h1, 2'd0);
`endif
    send(34'h5000, 32'h0000_0001, 4'h1, 2'd0, g);
    repeat (4) cyc();
    send(34'h5000, 32'h0000_0077, 4'h1, 2'd0, g);
    wait_req(c);
    chk("lat_after_second", 64'(c - g), 64'(LAT));
    wait_idle();

    // Reset while in ISSUE discards the entry
    gnt_en = 1'b0;
    send(34'h4000, 32'h0000_CAFE, 4'h3, 2'd1, g);
    wait_req(c);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_issue_dc_req", 64'(dc_req),  64'd0);
    chk("rst_issue_empty",  64'(empty),   64'd1);
    chk("rst_issue_gnt",    64'(stb_gnt), 64'd0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_rst_dc_req", 64'(dc_req), 64'd0);
    chk("after_rst_empty",  64'(empty),  64'd1);
    cyc();
    gnt_en = 1'b1;
    repeat (3) cyc();
    chk("no_leftover_expected", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
